cdma_req_splitter: RTL and testbench

- Request sequencer directly upstream of the unaligned CDMA command port; one instance per direction (rd and wr).
- Accepts large transfer requests with a wide length and splits each into datamover commands that never cross a 2^CHUNK_BITS byte boundary.
- Tracks outstanding commands against the datamover status pulses and emits a single completion pulse per original request.

---
 rtl/cdma_req_splitter.sv | 115 +++++++++++
 tb/tb_cdma_req_splitter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdma_req_splitter.sv
// Splits large client transfer requests into CDMA commands that never cross a
// 2^CHUNK_BITS byte boundary, tracks their completion and reports one done per request.
module cdma_req_splitter #(
  parameter int ADDR_BITS       = 34,
  parameter int LEN_BITS        = 26,
  parameter int REQ_LEN_BITS    = 32,
  parameter int CHUNK_BITS      = 20,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_req_valid,
  output logic                    s_req_ready,
  input  logic [ADDR_BITS-1:0]    s_req_paddr,
  input  logic [REQ_LEN_BITS-1:0] s_req_len,
  output logic                    s_req_done,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic [ADDR_BITS-1:0]    m_cmd_paddr,
  output logic [LEN_BITS-1:0]     m_cmd_len,
  input  logic                    m_cmd_done,
  output logic                    busy,
  output logic                    err_underflow
);

  localparam int OUTST_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW         = CHUNK_BITS + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [REQ_LEN_BITS-1:0] rem_q;
  logic [OUTST_BITS-1:0]   outst_q, outst_next;
  logic                    err_q;
  logic                    underflow_evt;

  logic [CW-1:0] room;
  logic [CW-1:0] chunk;
  logic          rem_fits;
  logic          accept;
  logic          cmd_hs;

  // Bytes left before the next chunk boundary; at most 2^CHUNK_BITS, never 0.
  assign room     = {1'b1, {CHUNK_BITS{1'b0}}} - {1'b0, addr_q[CHUNK_BITS-1:0]};
  assign rem_fits = rem_q <= REQ_LEN_BITS'(room);
  assign chunk    = rem_fits ? rem_q[CW-1:0] : room;

  assign accept = s_req_valid && s_req_ready;
  assign cmd_hs = m_cmd_valid && m_cmd_ready;

  always_comb begin
    outst_next    = outst_q;
    underflow_evt = 1'b0;
    if (cmd_hs && !m_cmd_done) begin
      outst_next = outst_q + OUTST_BITS'(1);
    end else if (!cmd_hs && m_cmd_done) begin
      if (outst_q == '0) underflow_evt = 1'b1;
      else               outst_next    = outst_q - OUTST_BITS'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (s_req_len == '0) ? DONE : ISSUE;
      ISSUE:   if (cmd_hs && rem_fits) state_next = DRAIN;
      // Looks at the post-update count so a final done finishes without an extra cycle.
      DRAIN:   if (outst_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_req_ready = (state_reg == IDLE);
    s_req_done  = (state_reg == DONE);
    busy        = (state_reg != IDLE);
    m_cmd_valid = 1'b0;
    m_cmd_paddr = '0;
    m_cmd_len   = '0;
    if (state_reg == ISSUE) begin
      m_cmd_valid = (outst_q < OUTST_BITS'(MAX_OUTSTANDING));
      m_cmd_paddr = addr_q;
      m_cmd_len   = LEN_BITS'(chunk);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= s_req_paddr;
        rem_q  <= s_req_len;
      end else if (cmd_hs) begin
        addr_q <= addr_q + ADDR_BITS'(chunk);
        rem_q  <= rem_q - REQ_LEN_BITS'(chunk);
      end
      outst_q <= outst_next;
      if (underflow_evt) err_q <= 1'b1;
    end
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_cdma_req_splitter.sv
// Randomized bench for cdma_req_splitter: expected commands come from a simple
// chunking model, completions are returned by a delayed-done responder.
module tb_cdma_req_splitter;

  localparam int AB = 34;
  localparam int LB = 26;
  localparam int RB = 32;
  localparam int CB = 20;
  localparam int MO = 8;
  localparam longint CHUNK = 64'd1 << CB;
  localparam longint AMOD  = 64'd1 << AB;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_req_valid;
  logic          s_req_ready;
  logic [AB-1:0] s_req_paddr;
  logic [RB-1:0] s_req_len;
  logic          s_req_done;
  logic          m_cmd_valid;
  logic          m_cmd_ready;
  logic [AB-1:0] m_cmd_paddr;
  logic [LB-1:0] m_cmd_len;
  logic          m_cmd_done;
  logic          busy;
  logic          err_underflow;

  int     total_cnt = 0;
  int     bad_cnt   = 0;
  bit     exp_err   = 1'b0;
  longint exp_a[$];
  longint exp_l[$];
  int     due_q[$];

  cdma_req_splitter #(
    .ADDR_BITS(AB), .LEN_BITS(LB), .REQ_LEN_BITS(RB), .CHUNK_BITS(CB), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_paddr(s_req_paddr), .s_req_len(s_req_len), .s_req_done(s_req_done),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_paddr(m_cmd_paddr), .m_cmd_len(m_cmd_len), .m_cmd_done(m_cmd_done),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference chunk list: walk the request, cutting at each 2^CB boundary.
  task automatic build_model(input longint paddr, input longint len);
    longint a, rem, room, c;
    exp_a.delete();
    exp_l.delete();
    a   = paddr;
    rem = len;
    while (rem > 0) begin
      room = CHUNK - (a % CHUNK);
      c    = (rem < room) ? rem : room;
      exp_a.push_back(a);
      exp_l.push_back(c);
      a    = (a + c) % AMOD;
      rem  = rem - c;
    end
  endtask

  task automatic do_request(input string name, input longint paddr, input longint len,
                            input int ready_pct, input int stall, input int dmin,
                            input int dmax, output int peak);
    int     ecnt, mo, dut_out, last_due, d;
    bit     fin, exp_valid, exp_done, rdy, dn, hs;
    longint ea, el;
    build_model(paddr, len);
    due_q.delete();
    ecnt = 0; mo = 0; dut_out = 0; last_due = 0; fin = 1'b0; peak = 0;
    @(negedge aclk);
    total_cnt++;
    if (s_req_ready !== 1'b1) begin
      bad_cnt++; $display("FAIL %s idle_ready: got %b want 1", name, s_req_ready);
    end
    s_req_valid = 1'b1;
    s_req_paddr = paddr[AB-1:0];
    s_req_len   = len[RB-1:0];
    m_cmd_ready = 1'b0;
    m_cmd_done  = 1'b0;
    @(posedge aclk);
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      @(negedge aclk);
      s_req_valid = 1'b0;
      exp_valid = (ecnt < exp_a.size()) && (mo < MO);
      total_cnt++;
      if (m_cmd_valid !== exp_valid) begin
        bad_cnt++;
        $display("FAIL %s valid cyc=%0d: got %b want %b", name, cyc, m_cmd_valid, exp_valid);
      end
      if (exp_valid && m_cmd_valid) begin
        ea = exp_a[ecnt];
        el = exp_l[ecnt];
        total_cnt++;
        if (m_cmd_paddr !== ea[AB-1:0]) begin
          bad_cnt++;
          $display("FAIL %s paddr cmd=%0d: got %h want %h", name, ecnt, m_cmd_paddr, ea[AB-1:0]);
        end
        total_cnt++;
        if (m_cmd_len !== el[LB-1:0]) begin
          bad_cnt++;
          $display("FAIL %s len cmd=%0d: got %h want %h", name, ecnt, m_cmd_len, el[LB-1:0]);
        end
      end
      exp_done = (ecnt == exp_a.size()) && (mo == 0);
      total_cnt++;
      if (s_req_done !== exp_done) begin
        bad_cnt++;
        $display("FAIL %s req_done cyc=%0d: got %b want %b", name, cyc, s_req_done, exp_done);
      end
      total_cnt++;
      if (busy !== 1'b1) begin
        bad_cnt++; $display("FAIL %s busy cyc=%0d: got %b want 1", name, cyc, busy);
      end
      if (exp_done) fin = 1'b1;
      rdy = (cyc > stall) && ($urandom_range(0, 99) < ready_pct);
      dn  = (due_q.size() > 0) && (due_q[0] <= cyc);
      if (dn) void'(due_q.pop_front());
      m_cmd_ready = rdy;
      m_cmd_done  = dn;
      hs = exp_valid && rdy;
      if (m_cmd_valid && rdy) dut_out++;
      if (dn) dut_out--;
      if (dut_out > peak) peak = dut_out;
      if (hs) begin
        ecnt++;
        d = int'($urandom_range(dmin, dmax));
        if (cyc + d > last_due) last_due = cyc + d;
        due_q.push_back(last_due);
      end
      mo = mo + int'(hs) - int'(dn);
    end
    total_cnt++;
    if (!fin) begin
      bad_cnt++; $display("FAIL %s timeout: got no s_req_done want s_req_done", name);
    end
    @(negedge aclk);
    m_cmd_ready = 1'b0;
    m_cmd_done  = 1'b0;
    total_cnt++;
    if (s_req_ready !== 1'b1 || s_req_done !== 1'b0 || busy !== 1'b0) begin
      bad_cnt++;
      $display("FAIL %s after_done: got ready=%b done=%b busy=%b want 1/0/0",
               name, s_req_ready, s_req_done, busy);
    end
    total_cnt++;
    if (err_underflow !== exp_err) begin
      bad_cnt++; $display("FAIL %s err_underflow: got %b want %b", name, err_underflow, exp_err);
    end
    $display("request %s paddr=%h len=%h cmds=%0d peak=%0d", name, paddr, len, exp_a.size(), peak);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_req_valid = 1'b0; s_req_paddr = '0; s_req_len = '0;
    m_cmd_ready = 1'b0; m_cmd_done = 1'b0;
    repeat (3) @(negedge aclk);
    total_cnt++;
    if (s_req_ready !== 1'b1 || s_req_done !== 1'b0 || m_cmd_valid !== 1'b0 ||
        m_cmd_paddr !== '0 || m_cmd_len !== '0 || busy !== 1'b0 || err_underflow !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_values: got rdy=%b done=%b v=%b pa=%h len=%h busy=%b err=%b want 1/0/0/0/0/0/0",
               s_req_ready, s_req_done, m_cmd_valid, m_cmd_paddr, m_cmd_len, busy, err_underflow);
    end
    aresetn = 1'b1;
    $display("reset: values checked");
  endtask

  task automatic test_aligned();
    int pk;
    do_request("aligned", 64'h0, 64'h300000, 100, 0, 10, 10, pk);
  endtask

  task automatic test_boundary();
    int pk;
    do_request("boundary", 64'hFF000, 64'h2000, 100, 0, 3, 3, pk);
    do_request("addr_wrap", 64'h3_FFFF_F000, 64'h3000, 100, 0, 2, 5, pk);
    do_request("one_byte", 64'h1_2345_6789, 64'h1, 100, 0, 1, 1, pk);
  endtask

  task automatic test_zero_len();
    int pk;
    do_request("zero_len", 64'h1234, 64'h0, 100, 0, 1, 1, pk);
  endtask

  task automatic test_credit_limit();
    int pk;
    do_request("credit", 64'h0, 64'h1000000, 100, 0, 40, 40, pk);
    total_cnt++;
    if (pk !== MO) begin
      bad_cnt++; $display("FAIL credit peak_outstanding: got %0d want %0d", pk, MO);
    end
  endtask

  task automatic test_back_to_back();
    int pk;
    do_request("backpressure", 64'h12345, 64'h900000, 100, 5, 1, 12, pk);
    do_request("simultaneous", 64'h40_0000, 64'h1000000, 70, 0, 6, 9, pk);
  endtask

  task automatic test_reset_mid();
    int pk;
    @(negedge aclk);
    s_req_valid = 1'b1; s_req_paddr = '0; s_req_len = 32'h1000000;
    @(posedge aclk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge aclk);
      s_req_valid = 1'b0;
      m_cmd_ready = 1'b1;
    end
    @(negedge aclk);
    total_cnt++;
    if (m_cmd_valid !== 1'b1 || m_cmd_paddr !== 34'h300000) begin
      bad_cnt++;
      $display("FAIL reset_mid pre: got v=%b pa=%h want 1/300000", m_cmd_valid, m_cmd_paddr);
    end
    aresetn = 1'b0;
    #1;
    total_cnt++;
    if (s_req_ready !== 1'b1 || s_req_done !== 1'b0 || m_cmd_valid !== 1'b0 ||
        m_cmd_paddr !== '0 || m_cmd_len !== '0 || busy !== 1'b0 || err_underflow !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_mid values: got rdy=%b done=%b v=%b pa=%h len=%h busy=%b err=%b want 1/0/0/0/0/0/0",
               s_req_ready, s_req_done, m_cmd_valid, m_cmd_paddr, m_cmd_len, busy, err_underflow);
    end
    m_cmd_ready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    m_cmd_done = 1'b1;
    @(negedge aclk);
    m_cmd_done = 1'b0;
    exp_err = 1'b1;
    total_cnt++;
    if (err_underflow !== 1'b1) begin
      bad_cnt++; $display("FAIL stray_done err_underflow: got %b want 1", err_underflow);
    end
    repeat (5) @(negedge aclk);
    total_cnt++;
    if (err_underflow !== 1'b1) begin
      bad_cnt++; $display("FAIL sticky err_underflow: got %b want 1", err_underflow);
    end
    $display("reset_mid: stray done err_underflow=%b", err_underflow);
    do_request("after_reset", 64'hABC00, 64'h180000, 80, 0, 1, 6, pk);
  endtask

  task automatic test_random();
    int     pk;
    longint pa, ln;
    for (int i = 0; i < 8; i++) begin
      pa = {30'd0, 2'($urandom_range(0, 3)), 32'($urandom)};
      case ($urandom_range(0, 3))
        0:       ln = longint'($urandom_range(1, 32'h3000));
        1:       ln = longint'($urandom_range(1, 32'h100000));
        2:       ln = longint'($urandom_range(32'h100000, 32'h500000));
        default: ln = longint'($urandom_range(1, 5)) * CHUNK;
      endcase
      do_request($sformatf("random%0d", i), pa, ln, int'($urandom_range(40, 100)), 0,
                 1, int'($urandom_range(1, 20)), pk);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_boundary();
    test_zero_len();
    test_credit_limit();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
